// File: rtl/neuron_pkg.sv
// Shared constants and state encoding for the integrate-and-fire neuron.
// W is the default potential width; the top derives its own width from n_stage.
package neuron_pkg;

    localparam int N_STAGE  = 10;
    localparam int W        = N_STAGE + 2;
    localparam int COUNT_W  = 8;
    localparam int REFRAC_W = 4;
    localparam int SHIFT_W  = 3;

    typedef enum logic [1:0] {
        INTEG  = 2'd0,
        FIRE   = 2'd1,
        REFRAC = 2'd2
    } neuron_state_t;

endpackage

// File: rtl/leak_sat_adder.sv
// Combinational membrane update: leak u by (u >> shift), then add the input
// current and clamp at the all-ones value instead of wrapping.
module leak_sat_adder
    import neuron_pkg::*;
#(
    parameter int WIDTH = W
) (
    input  logic [WIDTH-1:0]   i_u,
    input  logic [SHIFT_W-1:0] i_shift,
    input  logic [WIDTH-1:0]   i_current,
    output logic [WIDTH-1:0]   o_sum
);

    logic [WIDTH-1:0] w_leak;
    logic [WIDTH:0]   w_wide;

    // shift=0 removes the whole potential, which is the intended "full leak"
    assign w_leak = i_u - (i_u >> i_shift);
    assign w_wide = {1'b0, w_leak} + {1'b0, i_current};
    assign o_sum  = w_wide[WIDTH] ? {WIDTH{1'b1}} : w_wide[WIDTH-1:0];

endmodule

// File: rtl/integrate_fire_neuron.sv
// Leaky integrate-and-fire neuron: integrates accepted current samples, emits a
// one-cycle spike on crossing threshold, then optionally ignores input for a refractory period.
module integrate_fire_neuron
    import neuron_pkg::*;
#(
    parameter int n_stage = N_STAGE
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [n_stage+1:0]  current,
    input  logic [SHIFT_W-1:0]  shift,
    input  logic [n_stage+1:0]  threshold,
    input  logic                reset_mode,
    input  logic [REFRAC_W-1:0] refrac_len,
    output logic [n_stage+1:0]  u_out,
    output logic                spike,
    output logic [COUNT_W-1:0]  spike_count
);

    localparam int WL = n_stage + 2;

    neuron_state_t       r_state;
    neuron_state_t       w_state_next;
    logic [WL-1:0]       r_u;
    logic [WL-1:0]       w_u_next;
    logic [REFRAC_W-1:0] r_cnt;
    logic [REFRAC_W-1:0] w_cnt_next;
    logic                r_spike;
    logic                w_spike_next;
    logic [COUNT_W-1:0]  r_count;
    logic [COUNT_W-1:0]  w_count_next;
    logic [WL-1:0]       w_sum;

    leak_sat_adder #(
        .WIDTH(WL)
    ) u_leak_sat_adder (
        .i_u      (r_u),
        .i_shift  (shift),
        .i_current(current),
        .o_sum    (w_sum)
    );

    assign in_ready    = ena && (r_state != FIRE);
    assign u_out       = r_u;
    assign spike       = r_spike;
    assign spike_count = r_count;

    // Everything holds when ena is low, which also stretches the FIRE cycle.
    always_comb begin
        w_state_next = r_state;
        w_u_next     = r_u;
        w_cnt_next   = r_cnt;
        w_spike_next = r_spike;
        w_count_next = r_count;
        if (ena) begin
            case (r_state)
                INTEG: begin
                    if (in_valid) begin
                        if (w_sum >= threshold) begin
                            w_u_next     = reset_mode ? (w_sum - threshold) : '0;
                            w_state_next = FIRE;
                            w_spike_next = 1'b1;
                            w_count_next = r_count + COUNT_W'(1);
                        end else begin
                            w_u_next = w_sum;
                        end
                    end
                end
                FIRE: begin
                    w_spike_next = 1'b0;
                    if (refrac_len != '0) begin
                        w_state_next = REFRAC;
                        w_cnt_next   = refrac_len;
                    end else begin
                        w_state_next = INTEG;
                    end
                end
                REFRAC: begin
                    // Samples accepted here are dropped; only the counter moves.
                    if (r_cnt <= REFRAC_W'(1)) begin
                        w_state_next = INTEG;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt - REFRAC_W'(1);
                    end
                end
                default: begin
                    w_state_next = INTEG;
                    w_cnt_next   = '0;
                    w_spike_next = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= INTEG;
            r_u     <= '0;
            r_cnt   <= '0;
            r_spike <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_u     <= w_u_next;
            r_cnt   <= w_cnt_next;
            r_spike <= w_spike_next;
            r_count <= w_count_next;
        end
    end

endmodule

// File: doc/integrate_fire_neuron.md
INTEGRATE_FIRE_NEURON -- requirements
Module: integrate_fire_neuron

Interface
REQ-001 SHALL have parameter n_stage, default 10; potential width W = n_stage+2 bits, unsigned.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port ena, input, 1, global enable; low freezes all state and forces in_ready=0.
REQ-005 SHALL have port in_valid, input, 1, input current sample present.
REQ-006 SHALL have port in_ready, output, 1, block accepts a sample this cycle.
REQ-007 SHALL have port current, input, W, unsigned synaptic current for this sample.
REQ-008 SHALL have port shift, input, 3, leak shift amount.
REQ-009 SHALL have port threshold, input, W, firing threshold.
REQ-010 SHALL have port reset_mode, input, 1, post-spike reset: 0 = to zero, 1 = subtract threshold.
REQ-011 SHALL have port refrac_len, input, 4, refractory period in cycles.
REQ-012 SHALL have port u_out, output, W, registered membrane potential.
REQ-013 SHALL have port spike, output, 1, registered spike pulse.
REQ-014 SHALL have port spike_count, output, 8, accumulated spike count.

Function
REQ-015 SHALL accept a sample on a rising edge where in_valid & in_ready & ena are all 1.
REQ-016 SHALL compute leak L = u - (u >> shift) on acceptance; shift=0 gives L = 0 (full leak).
REQ-017 SHALL compute S = L + current, saturating at 2^W-1.
REQ-018 SHALL load u with S when S < threshold; state remains INTEG.
REQ-019 SHALL, when S >= threshold, load u with 0 (reset_mode=0) or S - threshold (reset_mode=1), and enter FIRE; threshold=0 fires on every accepted sample.
REQ-020 SHALL hold the FSM in states INTEG, FIRE, REFRAC: INTEG->FIRE on spike; FIRE->REFRAC after exactly one cycle if refrac_len != 0, else FIRE->INTEG; REFRAC->INTEG when its counter expires.
REQ-021 SHALL assert spike high only during the single FIRE cycle, one cycle after the accepting edge.
REQ-022 SHALL drive in_ready=0 in FIRE and in_ready=ena in INTEG and REFRAC.
REQ-023 SHALL, in REFRAC, accept and discard samples, leave u unchanged, and stay refrac_len cycles.
REQ-024 SHALL sample refrac_len on entry to REFRAC; changes during REFRAC have no effect.
REQ-025 SHALL increment spike_count once per FIRE cycle, wrapping 255->0.
REQ-026 SHALL, with ena=0, hold u, state, refractory counter, spike and spike_count; the FIRE cycle is extended while ena=0.
REQ-027 SHALL sample shift, threshold and reset_mode only at the accepting edge.

Reset
REQ-028 SHALL, on rst_n low and independent of clk, set u_out=0, spike=0, spike_count=0, refractory counter=0, state=INTEG.
REQ-029 SHALL abort any FIRE or REFRAC on reset mid-operation; the first sample after release is processed in INTEG.
REQ-030 SHALL drive in_ready=ena immediately after reset release.

Structure
REQ-031 SHALL place width constant W, state encoding (INTEG, FIRE, REFRAC) and the spike_count width in shared package neuron_pkg.
REQ-032 SHALL implement the leak-plus-saturating-add datapath as combinational sub-module leak_sat_adder; FSM and registers stay in the top module.

Verification
REQ-033 SHALL cover the leak case: W=12, u=1024, shift=2, current=0, threshold=4095 -> u_out=768 next cycle, no spike.
REQ-034 SHALL cover the fire case: u=1000, shift=3, current=200, threshold=1000, reset_mode=1, refrac_len=3 -> S=1075, u_out=75, spike for 1 cycle, in_ready=0 that cycle, then 3 REFRAC cycles with samples discarded and u_out=75 held.
REQ-035 SHALL cover saturation: u=4095, shift=7, current=4095, threshold=0, reset_mode=0 -> S=4095, spike, u_out=0, refrac_len=0 returns to INTEG after FIRE.
REQ-036 SHALL cover wrap: 256 spikes -> spike_count returns to 0.
REQ-037 SHALL cover async reset: rst_n pulsed low mid-REFRAC between clock edges -> all outputs 0 immediately, in_ready=ena after release.
REQ-038 SHALL cover enable gating: ena=0 during FIRE for 4 cycles -> spike stays high and spike_count increments once.
